// File: rtl/synchronous_counter.sv
// rtl/synchronous_counter.sv - free-running up-counter with synchronous parallel load
// Optional registered terminal-count output tc enabled by SYNC_COUNTER_TC_EN.
module synchronous_counter #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
`ifdef SYNC_COUNTER_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = data;
        end else begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef SYNC_COUNTER_TC_EN
    logic tc_d;
    logic tc_q;

    // Decoded from the next count so tc lines up with count in the same cycle.
    always_comb begin
        tc_d = (count_d == ALL_ONES);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_q <= (RESET_VALUE == ALL_ONES);
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;
`endif

endmodule

// File: tb/tb_synchronous_counter.sv
// tb/tb_synchronous_counter.sv - self-checking bench for synchronous_counter (WIDTH=4)
module tb_synchronous_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] data;
    logic [3:0] count;
`ifdef SYNC_COUNTER_TC_EN
    logic       tc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    synchronous_counter #(
        .WIDTH       (4),
        .RESET_VALUE (4'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
`ifdef SYNC_COUNTER_TC_EN
        .tc    (tc),
`endif
        .count (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_tc(input string tag, input logic exp);
`ifdef SYNC_COUNTER_TC_EN
        check(tag, {31'b0, tc}, {31'b0, exp});
`endif
    endtask

    logic [3:0] model;
    logic       r_rst;
    logic       r_load;
    logic [3:0] r_data;

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        data = 4'h0;
        #1;
        check("reset_async", count, 4'h0);
        check_tc("reset_tc", 1'b0);

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", count, 4'h0);
        end

        load = 1'b1;
        data = 4'h7;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("prio_rst_over_load", count, 4'h0);
        end

        rst  = 1'b1;
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("release_count", count, i);
        end

        load = 1'b1;
        data = 4'hA;
        tick();
        check("load_a", count, 4'hA);
        load = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            tick();
            check("after_load", count, i);
        end

        load = 1'b1;
        data = 4'hE;
        tick();
        check("load_e", count, 4'hE);
        check_tc("tc_at_e", 1'b0);
        load = 1'b0;
        tick();
        check("wrap_15", count, 4'hF);
        check_tc("tc_at_15", 1'b1);
        tick();
        check("wrap_0", count, 4'h0);
        check_tc("tc_at_0", 1'b0);
        tick();
        check("wrap_1", count, 4'h1);

        load = 1'b1;
        data = 4'hC;
        tick();
        load = 1'b0;
        check("load_c", count, 4'hC);
        #2 rst = 1'b0;
        #1;
        check("async_mid_cycle", count, 4'h0);
        check_tc("async_tc", 1'b0);
        #2 rst = 1'b1;
        tick();
        check("async_release", count, 4'h1);

        load = 1'b1;
        data = 4'h3;
        tick();
        check("held_load_3", count, 4'h3);
        data = 4'h9;
        tick();
        check("held_load_9", count, 4'h9);

        data = 4'hF;
        tick();
        check("load_f", count, 4'hF);
        check_tc("tc_load_f", 1'b1);
        load = 1'b0;
        tick();
        check("load_f_wrap", count, 4'h0);
        check_tc("tc_after_wrap", 1'b0);

        model = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            r_rst  = ($urandom_range(0, 15) != 0);
            r_load = $urandom_range(0, 3) == 0;
            r_data = 4'($urandom_range(0, 15));
            rst    = r_rst;
            load   = r_load;
            data   = r_data;
            tick();
            if (!r_rst) begin
                model = 4'h0;
            end else if (r_load) begin
                model = r_data;
            end else begin
                model = model + 4'h1;
            end
            check("random_count", count, model);
            check_tc("random_tc", model == 4'hF);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
